// File: rtl/monitor_frame_tx.sv
// monitor_frame_tx
// Packs the health-monitor state (XADC measurements, alarm word, device DNA)
// into a fixed 32-byte status frame and streams it out over a valid/ready
// byte interface. A frame is requested by the period timer or by a start
// pulse. All inputs are snapshotted when the frame begins.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 single-cycle frame request
//   meas_*                XADC results (16 bit each)
//   alm                   XADC alarm word
//   dna_valid, dna_data   device DNA capture flag and value
//   tx_data/valid/ready/last   byte stream to the host link
//   busy                  frame in progress
//   merged_cnt            saturating count of triggers merged into a pending request
//
// Build option: define MON_TX_CRC8_EN to make byte 31 a CRC-8 (poly 0x07,
// init 0, MSB first) over bytes 2..30 instead of the mod-256 sum.
//
// state  | meaning
// IDLE   | no frame on the wire; waits for pending, then snapshots inputs
// SEND   | presenting byte[idx]; advances on each accepted byte
module monitor_frame_tx #(
    parameter int unsigned PERIOD_CYCLES = 100000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] meas_temp,
    input  logic [15:0] meas_vccint,
    input  logic [15:0] meas_vccaux,
    input  logic [15:0] meas_vccbram,
    input  logic [15:0] meas_aux0,
    input  logic [15:0] meas_aux1,
    input  logic [15:0] meas_aux2,
    input  logic [15:0] meas_aux3,
    input  logic [15:0] alm,
    input  logic        dna_valid,
    input  logic [56:0] dna_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic [7:0]  merged_cnt
);

    localparam int unsigned P_LAST = (PERIOD_CYCLES == 0) ? 0 : PERIOD_CYCLES - 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         pend_q, pend_d;
    logic [7:0]   merged_q, merged_d;
    logic [7:0]   seq_q, seq_d;
    logic [7:0]   data_q, data_d;
    logic [7:0]   chk_q, chk_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic [4:0]   idx_q, idx_d;
    logic [127:0] snap_meas_q, snap_meas_d;
    logic [15:0]  snap_alm_q, snap_alm_d;
    logic         snap_dv_q, snap_dv_d;
    logic [56:0]  snap_dna_q, snap_dna_d;

    logic         tick, trig, consume, accept;
    logic [1:0]   n_merge;
    logic [8:0]   msum;
    logic [4:0]   idx_nxt, bsel;
    logic [7:0]   chk_nxt;
    logic [247:0] frame_v;

    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef MON_TX_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return acc + b;
`endif
    endfunction

    always_comb begin
        tick    = (PERIOD_CYCLES != 0) && (cnt_q == CNT_W'(P_LAST));
        trig    = tick | start;
        consume = (state_q == S_IDLE) && pend_q;
        accept  = valid_q && tx_ready;

        state_d     = state_q;
        cnt_d       = (PERIOD_CYCLES == 0) ? '0 : (tick ? '0 : cnt_q + CNT_W'(1));
        seq_d       = seq_q;
        data_d      = data_q;
        chk_d       = chk_q;
        valid_d     = valid_q;
        last_d      = last_q;
        idx_d       = idx_q;
        snap_meas_d = snap_meas_q;
        snap_alm_d  = snap_alm_q;
        snap_dv_d   = snap_dv_q;
        snap_dna_d  = snap_dna_q;

        // A trigger arriving while a request is still waiting is merged.
        // Tick and start together on an empty request: one sets, one merges.
        pend_d  = (pend_q && !consume) || trig;
        n_merge = 2'd0;
        if (pend_q && !consume)
            n_merge = {1'b0, tick} + {1'b0, start};
        else if (tick && start)
            n_merge = 2'd1;
        msum     = {1'b0, merged_q} + {7'b0, n_merge};
        merged_d = msum[8] ? 8'hFF : msum[7:0];

        // Bytes 0..30 of the frame as one vector; byte 31 comes from the check.
        frame_v = {8'hA5, 8'h5A, seq_q, 8'h1B, snap_meas_q, snap_alm_q,
                   7'b0, snap_dv_q, 7'b0, snap_dna_q};
        idx_nxt = idx_q + 5'd1;
        bsel    = 5'd30 - idx_nxt;
        chk_nxt = (idx_q >= 5'd2) ? chk_step(chk_q, data_q) : chk_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    snap_meas_d = {meas_temp, meas_vccint, meas_vccaux, meas_vccbram,
                                   meas_aux0, meas_aux1, meas_aux2, meas_aux3};
                    snap_alm_d  = alm;
                    snap_dv_d   = dna_valid;
                    snap_dna_d  = dna_data;
                    idx_d       = 5'd0;
                    chk_d       = 8'd0;
                    valid_d     = 1'b1;
                    data_d      = 8'hA5;
                    last_d      = 1'b0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (accept) begin
                    if (idx_q == 5'd31) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 8'd0;
                        seq_d   = seq_q + 8'd1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = idx_nxt;
                        chk_d  = chk_nxt;
                        data_d = (idx_nxt == 5'd31) ? chk_nxt : frame_v[{bsel, 3'b000} +: 8];
                        last_d = (idx_nxt == 5'd31);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            merged_q    <= 8'd0;
            seq_q       <= 8'd0;
            data_q      <= 8'd0;
            chk_q       <= 8'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= 5'd0;
            snap_meas_q <= '0;
            snap_alm_q  <= '0;
            snap_dv_q   <= 1'b0;
            snap_dna_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            merged_q    <= merged_d;
            seq_q       <= seq_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            snap_meas_q <= snap_meas_d;
            snap_alm_q  <= snap_alm_d;
            snap_dv_q   <= snap_dv_d;
            snap_dna_q  <= snap_dna_d;
        end
    end

    assign tx_data    = data_q;
    assign tx_valid   = valid_q;
    assign tx_last    = last_q;
    assign busy       = (state_q == S_SEND);
    assign merged_cnt = merged_q;

endmodule

// File: tb/tb_monitor_frame_tx.sv
// Bench for monitor_frame_tx: a start-driven instance (timer off) exercised
// with directed and random traffic, plus a timer-driven instance (period 100)
// checked for first-frame timing and sequence wrap.
module tb_monitor_frame_tx;

    typedef logic [7:0] frame_t [32];

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, tx_ready;
    logic [15:0] meas [8];
    logic [15:0] alm;
    logic        dna_valid;
    logic [56:0] dna_data;
    logic [7:0]  tx_data, merged_cnt;
    logic        tx_valid, tx_last, busy;

    logic        reset_t;
    logic        start_t = 1'b0;
    logic        tx_ready_t = 1'b1;
    logic [7:0]  tx_data_t, merged_cnt_t;
    logic        tx_valid_t, tx_last_t, busy_t;

    monitor_frame_tx #(.PERIOD_CYCLES(0), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .meas_temp(meas[0]), .meas_vccint(meas[1]), .meas_vccaux(meas[2]), .meas_vccbram(meas[3]),
        .meas_aux0(meas[4]), .meas_aux1(meas[5]), .meas_aux2(meas[6]), .meas_aux3(meas[7]),
        .alm(alm), .dna_valid(dna_valid), .dna_data(dna_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .merged_cnt(merged_cnt)
    );

    monitor_frame_tx #(.PERIOD_CYCLES(100), .CNT_W(32)) u_tmr (
        .clk(clk), .reset(reset_t), .start(start_t),
        .meas_temp(meas[0]), .meas_vccint(meas[1]), .meas_vccaux(meas[2]), .meas_vccbram(meas[3]),
        .meas_aux0(meas[4]), .meas_aux1(meas[5]), .meas_aux2(meas[6]), .meas_aux3(meas[7]),
        .alm(alm), .dna_valid(dna_valid), .dna_data(dna_data),
        .tx_data(tx_data_t), .tx_valid(tx_valid_t), .tx_ready(tx_ready_t), .tx_last(tx_last_t),
        .busy(busy_t), .merged_cnt(merged_cnt_t)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame built straight from the field layout; the check byte is
    // either a plain sum or a bit-serial CRC over the message bits.
    function automatic frame_t model_frame(input logic [7:0] seq, input logic [15:0] m [8],
                                           input logic [15:0] a, input logic dv,
                                           input logic [56:0] dna);
        frame_t      f;
        logic [63:0] d64;
        logic [7:0]  acc;
        logic        fb;
        int          s;
        f[0] = 8'hA5; f[1] = 8'h5A; f[2] = seq; f[3] = 8'd27;
        for (int i = 0; i < 8; i++) begin
            f[4+2*i] = m[i][15:8];
            f[5+2*i] = m[i][7:0];
        end
        f[20] = a[15:8]; f[21] = a[7:0];
        f[22] = {7'b0, dv};
        d64 = {7'b0, dna};
        for (int i = 0; i < 8; i++) f[23+i] = d64[63-8*i -: 8];
        acc = 8'd0;
        s = 0;
`ifdef MON_TX_CRC8_EN
        for (int i = 2; i <= 30; i++)
            for (int b = 7; b >= 0; b--) begin
                fb  = acc[7] ^ f[i][b];
                acc = {acc[6:0], 1'b0};
                if (fb) acc = acc ^ 8'h07;
            end
`else
        for (int i = 2; i <= 30; i++) s += int'(f[i]);
        acc = 8'(s % 256);
`endif
        f[31] = acc;
        return f;
    endfunction

    // Byte collector and handshake-stability watcher for the main instance.
    logic [7:0] rx_q [$];
    logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = 8'd0;
    int         busy_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, pd);
                check("hold_last", tx_last, pl);
            end
            if (tx_valid && tx_ready) begin
                check("last_flag", tx_last, 64'((rx_q.size() % 32) == 31));
                rx_q.push_back(tx_data);
            end
            if (busy) busy_cyc++;
            pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
        end
    end

    // Ready driver: 0 always ready, 1 random, 2 stall on byte 10 until rel, 3 never ready.
    int rdy_mode = 0;
    bit rel = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            2: tx_ready = rel || ((rx_q.size() % 32) != 10);
            default: tx_ready = 1'b0;
        endcase
    end

    // Timer instance watcher.
    int tcyc = 0, tfirst = -1, tframes = 0, tidx = 0;
    bit t_done = 1'b0;
    always @(negedge clk) begin
        if (reset_t) begin
            tcyc = 0; tidx = 0;
        end else begin
            if (tx_valid_t && tfirst < 0) begin
                tfirst = tcyc;
                check("timer_first_valid", 64'(tcyc), 101);
            end
            if (tx_valid_t && tx_ready_t) begin
                if (tidx == 2 && tframes <= 256)
                    check($sformatf("timer_seq%0d", tframes), tx_data_t, 64'(tframes % 256));
                if (tidx == 31) begin
                    tframes++;
                    tidx = 0;
                    if (tframes == 257) t_done = 1'b1;
                end else begin
                    tidx++;
                end
            end
            tcyc++;
        end
    end

    logic [15:0] s_meas [8];
    logic [15:0] s_alm;
    logic        s_dv;
    logic [56:0] s_dna;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic take_snap();
        for (int i = 0; i < 8; i++) s_meas[i] = meas[i];
        s_alm = alm; s_dv = dna_valid; s_dna = dna_data;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 8; i++) meas[i] = 16'($urandom);
        alm = 16'($urandom);
        dna_valid = 1'($urandom_range(0, 1));
        dna_data = {25'($urandom), 32'($urandom)};
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
        rx_q.delete();
    endtask

    task automatic wait_bytes(input int n);
        int c = 0;
        while (rx_q.size() < n && c < 2000) begin
            @(negedge clk); c++;
        end
        check($sformatf("wait_bytes%0d", n), 64'(rx_q.size() >= n), 1);
        step();
    endtask

    task automatic check_frame(input int base, input frame_t e, input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_b%0d", tag, i), (base + i < rx_q.size()) ? rx_q[base+i] : 8'hxx, e[i]);
    endtask

    initial begin
        int lat, c;
        reset = 1'b1; reset_t = 1'b1; start = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) meas[i] = 16'h0;
        alm = 16'h0; dna_valid = 1'b0; dna_data = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_merged", merged_cnt, 0);
        check("rst_tx_data", tx_data, 0);
        @(posedge clk); #1;
        reset = 1'b0; reset_t = 1'b0;

        // Basic frame, always ready.
        meas[0] = 16'h1234; dna_valid = 1'b1; dna_data = 57'h1;
        take_snap();
        step();
        busy_cyc = 0;
        pulse_start();
        lat = 1;
        @(negedge clk);
        while (!tx_valid && lat < 10) begin
            @(negedge clk); lat++;
        end
        check("start_latency", 64'(lat), 2);
        step();
        wait_bytes(32);
        repeat (3) step();
        check("busy_cycles", 64'(busy_cyc), 32);
        check("busy_idle", busy, 0);
        check_frame(0, model_frame(8'd0, s_meas, s_alm, s_dv, s_dna), "basic");

        // Random backpressure, same inputs.
        rdy_mode = 1;
        pulse_start();
        wait_bytes(64);
        check_frame(32, model_frame(8'd1, s_meas, s_alm, s_dv, s_dna), "bp");

        // Inputs change while byte 10 is stalled.
        rel = 1'b0; rdy_mode = 2;
        step();
        pulse_start();
        c = 0;
        @(negedge clk);
        while (!(tx_valid && rx_q.size() == 74) && c < 200) begin
            @(negedge clk); c++;
        end
        check("stall_reached", 64'(rx_q.size()), 74);
        step(); step();
        randomize_inputs();
        repeat (3) step();
        rel = 1'b1;
        wait_bytes(96);
        check_frame(64, model_frame(8'd2, s_meas, s_alm, s_dv, s_dna), "snap_old");
        rdy_mode = 0; step(); rel = 1'b0;
        take_snap();
        pulse_start();
        wait_bytes(128);
        check_frame(96, model_frame(8'd3, s_meas, s_alm, s_dv, s_dna), "snap_new");

        // Random content with random backpressure; inputs move after the snapshot.
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            randomize_inputs();
            take_snap();
            pulse_start();
            step(); step();
            randomize_inputs();
            wait_bytes(160 + 32 * k);
            check_frame(128 + 32 * k, model_frame(8'(4 + k), s_meas, s_alm, s_dv, s_dna),
                        $sformatf("rnd%0d", k));
        end

        // Three starts during a frame merge into one extra frame.
        rdy_mode = 0;
        do_reset();
        take_snap();
        pulse_start();
        repeat (5) step();
        pulse_start(); step(); step();
        pulse_start(); step(); step();
        pulse_start();
        wait_bytes(64);
        repeat (60) step();
        check("merge_bytes", 64'(rx_q.size()), 64);
        check("merge_cnt", merged_cnt, 2);
        check_frame(0, model_frame(8'd0, s_meas, s_alm, s_dv, s_dna), "merge_f0");
        check_frame(32, model_frame(8'd1, s_meas, s_alm, s_dv, s_dna), "merge_f1");

        // Merge counter saturation: start held high while the frame is stalled.
        do_reset();
        rdy_mode = 3;
        pulse_start();
        repeat (3) step();
        start = 1'b1;
        repeat (300) step();
        start = 1'b0;
        check("merge_sat", merged_cnt, 255);
        rdy_mode = 0;
        wait_bytes(64);
        repeat (60) step();
        check("sat_bytes", 64'(rx_q.size()), 64);

        // Reset in the middle of a frame.
        do_reset();
        pulse_start();
        c = 0;
        @(negedge clk);
        while (!(tx_valid && rx_q.size() == 15) && c < 200) begin
            @(negedge clk); c++;
        end
        check("mid_reached", 64'(rx_q.size()), 15);
        step();
        do_reset();
        @(negedge clk);
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        step();
        take_snap();
        pulse_start();
        wait_bytes(32);
        check_frame(0, model_frame(8'd0, s_meas, s_alm, s_dv, s_dna), "after_rst");

        c = 0;
        while (!t_done && c < 40000) begin
            step(); c++;
        end
        check("timer_done", 64'(t_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
